// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative shift-add multiply / restoring divide, one bit per cycle
module muldiv_sequencer #(
  parameter int WIDTH = 16,
  parameter int OP_L  = 3,
  parameter int CNT_L = 5
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Flush,
  input  logic             IssueValid,
  output logic             IssueReady,
  input  logic [OP_L-1:0]  Opcode,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic [WIDTH-1:0] Immediate,
  output logic             ResultValid,
  input  logic             ResultReady,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             DivByZero,
  output logic             Illegal,
  output logic             Busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] hi, lo, b, hi_n, lo_n, b_n, res_lo_n, res_hi_n, opb;
  logic [CNT_L-1:0] cnt, cnt_n;
  logic is_div, div_n, dbz_n, ill_n, op_mul, op_div, op_imm;
  logic [WIDTH:0] m_sum, d_sh, d_diff;
  logic d_ok;
  assign op_mul = Opcode == OP_L'(7) || Opcode == OP_L'(1);
  assign op_div = Opcode == OP_L'(0) || Opcode == OP_L'(2);
  assign op_imm = Opcode == OP_L'(1) || Opcode == OP_L'(2);
  assign opb = op_imm ? Immediate : OperandB;
  assign IssueReady = state == IDLE;
  assign ResultValid = state == DONE;
  assign Busy = state != IDLE;
  // multiply: hi accumulates, product low bits shift into lo behind the multiplier
  assign m_sum = {1'b0, hi} + {1'b0, lo[0] ? b : '0};
  // divide: hi is the remainder, lo the quotient; one extra bit covers the shifted remainder
  assign d_sh = {hi, lo[WIDTH-1]};
  assign d_diff = d_sh - {1'b0, b};
  assign d_ok = d_sh >= {1'b0, b};
  always_comb begin
    state_n = state;
    hi_n = hi;
    lo_n = lo;
    b_n = b;
    cnt_n = cnt;
    div_n = is_div;
    res_lo_n = ResultLo;
    res_hi_n = ResultHi;
    dbz_n = DivByZero;
    ill_n = 1'b0;
    if (Flush) state_n = IDLE;
    else if (state == IDLE) begin
      if (IssueValid && !(op_mul || op_div)) ill_n = 1'b1;
      else if (IssueValid) begin
        b_n = op_div ? opb : OperandA;
        lo_n = op_div ? OperandA : opb;
        hi_n = '0;
        cnt_n = CNT_L'(WIDTH);
        div_n = op_div;
        state_n = op_div && opb == '0 ? DONE : RUN;
        if (op_div && opb == '0) begin
          res_lo_n = '1;
          res_hi_n = OperandA;
          dbz_n = 1'b1;
        end
      end
    end else if (state == RUN) begin
      hi_n = is_div ? (d_ok ? d_diff[WIDTH-1:0] : d_sh[WIDTH-1:0]) : m_sum[WIDTH:1];
      lo_n = is_div ? {lo[WIDTH-2:0], d_ok} : {m_sum[0], lo[WIDTH-1:1]};
      cnt_n = cnt - 1'b1;
      if (cnt == CNT_L'(1)) begin
        state_n = DONE;
        res_lo_n = lo_n;
        res_hi_n = hi_n;
        dbz_n = 1'b0;
      end
    end else if (ResultReady) state_n = IDLE;
  end
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      b <= '0;
      cnt <= '0;
      is_div <= 1'b0;
      ResultLo <= '0;
      ResultHi <= '0;
      DivByZero <= 1'b0;
      Illegal <= 1'b0;
    end else begin
      state <= state_n;
      hi <= hi_n;
      lo <= lo_n;
      b <= b_n;
      cnt <= cnt_n;
      is_div <= div_n;
      ResultLo <= res_lo_n;
      ResultHi <= res_hi_n;
      DivByZero <= dbz_n;
      Illegal <= ill_n;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors with hand-computed results
module tb_muldiv_sequencer;
  logic Clock = 1'b0, Reset_n = 1'b0, Flush = 1'b0, IssueValid = 1'b0, ResultReady = 1'b0;
  logic [2:0] Opcode = 3'b000;
  logic [15:0] OperandA = '0, OperandB = '0, Immediate = '0;
  logic IssueReady, ResultValid, DivByZero, Illegal, Busy;
  logic [15:0] ResultLo, ResultHi;
  int tests = 0, fails = 0;
  localparam logic [2:0] MUL = 3'b111, DIV = 3'b000, MULI = 3'b001, DIVI = 3'b010, LUI = 3'b011;
  muldiv_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n), .Flush(Flush), .IssueValid(IssueValid),
    .IssueReady(IssueReady), .Opcode(Opcode), .OperandA(OperandA), .OperandB(OperandB),
    .Immediate(Immediate), .ResultValid(ResultValid), .ResultReady(ResultReady),
    .ResultLo(ResultLo), .ResultHi(ResultHi), .DivByZero(DivByZero), .Illegal(Illegal),
    .Busy(Busy)
  );
  always #5 Clock = ~Clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [2:0] op, input logic [15:0] a, input logic [15:0] bv, input logic [15:0] imm);
    @(negedge Clock);
    Opcode = op;
    OperandA = a;
    OperandB = bv;
    Immediate = imm;
    IssueValid = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    IssueValid = 1'b0;
  endtask
  task automatic wait_valid(input string tag, input int exp_lat);
    int n = 0;
    while (!ResultValid && n < 40) begin
      @(negedge Clock);
      n++;
    end
    check(tag, n, exp_lat);
  endtask
  task automatic result(input string tag, input logic [15:0] lo, input logic [15:0] hi, input logic dbz);
    check({tag, "_lo"}, ResultLo, lo);
    check({tag, "_hi"}, ResultHi, hi);
    check({tag, "_dbz"}, DivByZero, dbz);
  endtask
  task automatic consume();
    ResultReady = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    ResultReady = 1'b0;
    check("idle_after_consume", {IssueReady, ResultValid, Busy}, 3'b100);
  endtask
  initial begin
    int seen;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    check("reset_ctrl", {IssueReady, ResultValid, DivByZero, Illegal, Busy}, 5'b10000);
    check("reset_res", {ResultHi, ResultLo}, 32'h0);
    start(MUL, 16'd3, 16'd5, 16'd0);
    check("busy_after_issue", {IssueReady, Busy}, 2'b01);
    wait_valid("mul_latency", 16);
    result("mul_3x5", 16'h000F, 16'h0000, 1'b0);
    consume();
    start(MUL, 16'hFFFF, 16'hFFFF, 16'd0);
    wait_valid("mul_max_latency", 16);
    result("mul_max", 16'h0001, 16'hFFFE, 1'b0);
    consume();
    start(MULI, 16'h1234, 16'd9, 16'd2);
    wait_valid("muli_latency", 16);
    result("muli", 16'h2468, 16'h0000, 1'b0);
    consume();
    start(DIVI, 16'd100, 16'd0, 16'd7);
    wait_valid("divi_latency", 16);
    result("divi", 16'd14, 16'd2, 1'b0);
    consume();
    start(DIV, 16'h8000, 16'h8000, 16'd0);
    wait_valid("div_eq_latency", 16);
    result("div_eq", 16'd1, 16'd0, 1'b0);
    consume();
    start(DIV, 16'hFFFF, 16'd3, 16'd9);
    wait_valid("div_reg_latency", 16);
    result("div_reg", 16'h5555, 16'h0000, 1'b0);
    consume();
    start(DIV, 16'h1234, 16'd0, 16'd5);
    wait_valid("dbz_latency", 0);
    result("dbz", 16'hFFFF, 16'h1234, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      check("hold_ctrl", {ResultValid, IssueReady, Busy}, 3'b101);
      check("hold_res", {ResultHi, ResultLo}, 32'h1234FFFF);
    end
    consume();
    start(LUI, 16'd1, 16'd2, 16'd3);
    check("illegal_pulse", {Illegal, Busy, IssueReady}, 3'b101);
    @(negedge Clock);
    check("illegal_once", {Illegal, Busy}, 2'b00);
    Flush = 1'b1;
    start(DIV, 16'h0042, 16'd0, 16'd0);
    Flush = 1'b0;
    check("flush_drops_issue", {Busy, ResultValid, Illegal}, 3'b000);
    start(MUL, 16'h00FF, 16'h00FF, 16'd0);
    repeat (7) @(negedge Clock);
    Flush = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Flush = 1'b0;
    check("flush_idle", {IssueReady, Busy}, 2'b10);
    check("flush_keeps_res", {ResultHi, ResultLo}, 32'h1234FFFF);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      seen += int'(ResultValid);
    end
    check("flush_no_result", seen, 0);
    start(DIV, 16'd500, 16'd3, 16'd0);
    repeat (3) @(negedge Clock);
    Reset_n = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    check("reset_mid_idle", {IssueReady, Busy}, 2'b10);
    check("reset_mid_clears", {ResultHi, ResultLo, 7'd0, DivByZero}, 40'h0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      seen += int'(ResultValid);
    end
    check("reset_no_result", seen, 0);
    start(MUL, 16'd6, 16'd7, 16'd0);
    wait_valid("mul_after_latency", 16);
    result("mul_6x7", 16'd42, 16'd0, 1'b0);
    consume();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
